cache_and_ram: RTL and testbench

//  Word-addressed 4096x32 main memory fronted by a direct-mapped, write-through,

---
 rtl/cache_and_ram_pkg.sv | 16 +
 rtl/cache_and_ram_main_ram.sv | 14 +
 rtl/cache_and_ram.sv | 56 +++++
 tb/tb_cache_and_ram.sv | 117 +++++++++++
 4 files changed

// File: rtl/cache_and_ram_pkg.sv
// cache_and_ram_pkg: shared sizes, mode encodings and cache line layout.
package cache_and_ram_pkg;
   localparam int DATA_W      = 32;
   localparam int RAM_DEPTH   = 4096;
   localparam int CACHE_LINES = 32;
   localparam int IDX_W       = 5;
   localparam int TAG_W       = 7;
   localparam int ADDR_W      = IDX_W + TAG_W;
   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] word;
   } line_t;
endpackage

// File: rtl/cache_and_ram_main_ram.sv
// main_ram: RAM_DEPTH x DATA_W backing store, synchronous write, same-cycle read.
import cache_and_ram_pkg::*;
module main_ram (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [RAM_DEPTH] = '{default: '0};
   assign rdata = mem[addr];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
endmodule

// File: rtl/cache_and_ram.sv
// cache_and_ram: direct-mapped write-through/write-allocate cache over a 4096-word RAM.
// Define CACHE_STATS_EN to add read hit/miss counters hit_cnt and miss_cnt.
import cache_and_ram_pkg::*;
module cache_and_ram (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       address,
   input  logic [DATA_W-1:0] data,
   input  logic              mode,
`ifdef CACHE_STATS_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
`endif
   output logic [DATA_W-1:0] out
);
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [DATA_W-1:0] ram_word;
   logic              hit;
   logic              unused_hi;
   line_t             lines [CACHE_LINES];
   assign idx       = address[IDX_W-1:0];
   assign tag       = address[ADDR_W-1:IDX_W];
   assign unused_hi = ^address[31:ADDR_W];
   assign hit       = lines[idx].valid && lines[idx].tag == tag;
   // reset blocks the RAM write so a colliding access leaves memory untouched
   main_ram u_ram (
      .clk   (clk),
      .we    (!reset && mode == MODE_WRITE),
      .addr  (address[ADDR_W-1:0]),
      .wdata (data),
      .rdata (ram_word)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         out <= '0;
         for (int i = 0; i < CACHE_LINES; i++) lines[i].valid <= 1'b0;
      end else if (mode == MODE_WRITE) begin
         lines[idx] <= '{valid: 1'b1, tag: tag, word: data};
      end else begin
         out <= hit ? lines[idx].word : ram_word;
         if (!hit) lines[idx] <= '{valid: 1'b1, tag: tag, word: ram_word};
      end
   end
`ifdef CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (mode == MODE_READ) begin
         hit_cnt  <= hit_cnt + 32'(hit);
         miss_cnt <= miss_cnt + 32'(!hit);
      end
   end
`endif
endmodule

// File: tb/tb_cache_and_ram.sv
// tb_cache_and_ram: directed checks of cache_and_ram reads, writes, eviction, aliasing and reset.
module tb_cache_and_ram;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] data = '0;
   logic        mode = 1'b0;
   logic [31:0] out;
   int checks = 0;
   int failures = 0;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   cache_and_ram dut (
      .clk     (clk),
      .reset   (reset),
      .address (address),
      .data    (data),
      .mode    (mode),
`ifdef CACHE_STATS_EN
      .hit_cnt (hit_cnt),
      .miss_cnt(miss_cnt),
`endif
      .out     (out)
   );

   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] d, input logic m);
      @(negedge clk);
      reset   = rst;
      address = a;
      data    = d;
      mode    = m;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, a, d, 1'b1);
   endtask

   task automatic rd(input logic [31:0] a);
      step(1'b0, a, 32'd0, 1'b0);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   initial begin
      step(1'b1, 32'd0, 32'd0, 1'b0);
      chk("reset_out", out, 32'd0);
`ifdef CACHE_STATS_EN
      chk("reset_hits", hit_cnt, 32'd0);
      chk("reset_misses", miss_cnt, 32'd0);
`endif
      rd(32'd0);
      chk("read0_empty", out, 32'd0);
`ifdef CACHE_STATS_EN
      chk("first_read_miss", miss_cnt, 32'd1);
`endif
      wr(32'd0, 32'd14528);
      chk("hold_on_write", out, 32'd0);
      rd(32'd0);
      chk("read0_after_write", out, 32'd14528);
      wr(32'd2816867292, 32'd526421);
      wr(32'd1001425, 32'd25369366);
      wr(32'd3036, 32'd14528);
      wr(32'd2001, 32'd14528);
      rd(32'd2001);
      chk("read2001_rewritten", out, 32'd14528);
      rd(32'd3036);
      chk("read3036_rewritten", out, 32'd14528);
      wr(32'd5, 32'd11);
      wr(32'd37, 32'd22);
      rd(32'd5);
      chk("conflict_read5", out, 32'd11);
      rd(32'd37);
      chk("conflict_read37", out, 32'd22);
      rd(32'd37);
      chk("reread37_hit", out, 32'd22);
      wr(32'h0000_1ABC, 32'd7);
      rd(32'hFFFF_FABC);
      chk("alias_read", out, 32'd7);
`ifdef CACHE_STATS_EN
      chk("hits_before_reset", hit_cnt, 32'd5);
      chk("misses_before_reset", miss_cnt, 32'd3);
`endif
      wr(32'd200, 32'd999);
      chk("hold_across_write", out, 32'd7);
      step(1'b1, 32'd0, 32'd0, 1'b0);
      chk("midreset_out", out, 32'd0);
      rd(32'd5);
      chk("post_reset_read5", out, 32'd11);
`ifdef CACHE_STATS_EN
      chk("post_reset_miss", miss_cnt, 32'd1);
      chk("post_reset_hits", hit_cnt, 32'd0);
`endif
      rd(32'd0);
      chk("post_reset_read0", out, 32'd14528);
      step(1'b1, 32'd100, 32'd99, 1'b1);
      chk("reset_with_write_out", out, 32'd0);
      rd(32'd100);
      chk("reset_blocks_write", out, 32'd0);
      rd(32'd200);
      chk("read200", out, 32'd999);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
